// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: three result sources, register-file write port,
// forwarding lookup and contention counter. The arbiter uses the slave modport.
interface wb_arbiter_if;
  logic        alu_valid, fpu_valid, mem_valid;
  logic [4:0]  alu_rd, fpu_rd, mem_rd;
  logic [31:0] alu_data, fpu_data, mem_data;
  logic        alu_ready, fpu_ready, mem_ready;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [4:0]  rs1, rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [15:0] conflict_cnt;

  modport master (
    output alu_valid, fpu_valid, mem_valid,
    output alu_rd, fpu_rd, mem_rd,
    output alu_data, fpu_data, mem_data,
    output rs1, rs2,
    input  alu_ready, fpu_ready, mem_ready,
    input  w_enable, w_addr, w_data,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
    input  conflict_cnt
  );

  modport slave (
    input  alu_valid, fpu_valid, mem_valid,
    input  alu_rd, fpu_rd, mem_rd,
    input  alu_data, fpu_data, mem_data,
    input  rs1, rs2,
    output alu_ready, fpu_ready, mem_ready,
    output w_enable, w_addr, w_data,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
    output conflict_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter (alu/fpu/mem -> register file) with 1-cycle write latency.
// Define WB_FORWARD_EN to build the write-to-read forwarding compare logic.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    LAST_ALU = 2'd0,
    LAST_FPU = 2'd1,
    LAST_MEM = 2'd2
  } last_t;

  last_t       r_last;
  last_t       w_last_nxt;
  logic [2:0]  w_valid;
  logic [2:0]  w_gnt;
  logic        w_xfer;
  logic        w_contend;
  logic [4:0]  w_sel_rd;
  logic [31:0] w_sel_data;
  logic        r_we;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [15:0] r_cnt;

  // bit 0 = alu, bit 1 = fpu, bit 2 = mem throughout
  assign w_valid   = {bus.mem_valid, bus.fpu_valid, bus.alu_valid};
  assign w_xfer    = |w_gnt;
  assign w_contend = (w_valid[0] & w_valid[1]) | (w_valid[0] & w_valid[2]) |
                     (w_valid[1] & w_valid[2]);

  // Round-robin grant search, next-state and selected-source mux
  always_comb begin
    w_gnt      = 3'b000;
    w_last_nxt = r_last;
    w_sel_rd   = 5'd0;
    w_sel_data = 32'd0;
    if (rst) begin
      w_gnt = 3'b000;
    end else begin
      case (r_last)
        LAST_ALU: begin
          if (w_valid[1])      w_gnt = 3'b010;
          else if (w_valid[2]) w_gnt = 3'b100;
          else if (w_valid[0]) w_gnt = 3'b001;
          else                 w_gnt = 3'b000;
        end
        LAST_FPU: begin
          if (w_valid[2])      w_gnt = 3'b100;
          else if (w_valid[0]) w_gnt = 3'b001;
          else if (w_valid[1]) w_gnt = 3'b010;
          else                 w_gnt = 3'b000;
        end
        default: begin
          // An illegal encoding falls back to alu-first so nothing can stall
          if (w_valid[0])      w_gnt = 3'b001;
          else if (w_valid[1]) w_gnt = 3'b010;
          else if (w_valid[2]) w_gnt = 3'b100;
          else                 w_gnt = 3'b000;
        end
      endcase
    end
    case (w_gnt)
      3'b001: begin
        w_last_nxt = LAST_ALU;
        w_sel_rd   = bus.alu_rd;
        w_sel_data = bus.alu_data;
      end
      3'b010: begin
        w_last_nxt = LAST_FPU;
        w_sel_rd   = bus.fpu_rd;
        w_sel_data = bus.fpu_data;
      end
      3'b100: begin
        w_last_nxt = LAST_MEM;
        w_sel_rd   = bus.mem_rd;
        w_sel_data = bus.mem_data;
      end
      default: begin
        w_last_nxt = r_last;
        w_sel_rd   = 5'd0;
        w_sel_data = 32'd0;
      end
    endcase
  end

  // Round-robin state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= LAST_MEM;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // Register-file write port and saturating contention counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= 5'd0;
      r_data <= 32'd0;
      r_cnt  <= 16'd0;
    end else begin
      // Writes to x0 complete the handshake but leave addr/data untouched
      if (w_xfer && (w_sel_rd != 5'd0)) begin
        r_we   <= 1'b1;
        r_addr <= w_sel_rd;
        r_data <= w_sel_data;
      end else begin
        r_we <= 1'b0;
      end
      if (w_contend && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.alu_ready    = w_gnt[0];
  assign bus.fpu_ready    = w_gnt[1];
  assign bus.mem_ready    = w_gnt[2];
  assign bus.w_enable     = r_we;
  assign bus.w_addr       = r_addr;
  assign bus.w_data       = r_data;
  assign bus.conflict_cnt = r_cnt;

`ifdef WB_FORWARD_EN
  logic w_hit1, w_hit2;
  assign w_hit1        = r_we && (r_addr == bus.rs1) && (bus.rs1 != 5'd0);
  assign w_hit2        = r_we && (r_addr == bus.rs2) && (bus.rs2 != 5'd0);
  assign bus.fwd1_hit  = w_hit1;
  assign bus.fwd2_hit  = w_hit2;
  assign bus.fwd1_data = w_hit1 ? r_data : 32'd0;
  assign bus.fwd2_data = w_hit2 ? r_data : 32'd0;
`else
  logic w_unused_rs;
  assign w_unused_rs   = ^{bus.rs1, bus.rs2};
  assign bus.fwd1_hit  = 1'b0;
  assign bus.fwd2_hit  = 1'b0;
  assign bus.fwd1_data = 32'd0;
  assign bus.fwd2_data = 32'd0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- alu_valid / fpu_valid / mem_valid  in  1  source holds a writeback result
- alu_rd / fpu_rd / mem_rd  in  5  destination register
- alu_data / fpu_data / mem_data  in  32  result value
- alu_ready / fpu_ready / mem_ready  out  1  grant; transfer occurs when valid && ready
- w_enable  out  1  register-file write strobe, registered
- w_addr  out  5  register-file write address, registered
- w_data  out  32  register-file write data, registered
- rs1, rs2  in  5  register-file read addresses, for forwarding
- fwd1_hit, fwd2_hit  out  1  pending write matches rs1 / rs2
- fwd1_data, fwd2_data  out  32  forwarded value
- conflict_cnt  out  16  saturating count of contended cycles

Function
REQ-003 The block SHALL assert at most one ready per cycle, and only to a source whose valid is high.
- ready is combinational from the valid inputs and the round-robin state.
REQ-004 Arbitration SHALL be round-robin using a state register last ∈ {LAST_ALU, LAST_FPU, LAST_MEM}.
- Search order: LAST_ALU -> fpu, mem, alu; LAST_FPU -> mem, alu, fpu; LAST_MEM -> alu, fpu, mem.
REQ-005 last SHALL update to the granted source only in a cycle with a transfer; otherwise last SHALL hold.
REQ-006 A source SHALL keep valid, rd and data stable until its transfer.
- A source that is not granted keeps waiting; it is never dropped.
REQ-007 On a transfer with rd != 0, the next cycle SHALL show w_enable=1, w_addr=rd, w_data=data.
- Latency: exactly 1 cycle.
REQ-008 On a transfer with rd == 0, the handshake SHALL complete and the next cycle SHALL show w_enable=0.
REQ-009 In a cycle with no transfer, the next cycle SHALL show w_enable=0; w_addr and w_data SHALL hold their previous values.
REQ-010 Throughput SHALL be one transfer per cycle; the register-file side has no backpressure.
REQ-011 conflict_cnt SHALL increment by 1 in every cycle where two or more valid inputs are high.
- It saturates at 16'hFFFF and never wraps.
REQ-012 Forwarding (see REQ-016) SHALL be combinational from w_enable, w_addr, w_data, rs1 and rs2.

Reset
REQ-013 While rst=1, all ready outputs SHALL be 0, and no transfer occurs even if a valid is high.
REQ-014 The cycle after rst is sampled high SHALL show:
- w_enable=0, w_addr=0, w_data=0
- last=LAST_MEM, so alu has first priority after reset
- conflict_cnt=0
REQ-015 Reset asserted while a result is in the output register SHALL discard that write: w_enable=0 next cycle.

Configuration
REQ-016 Macro WB_FORWARD_EN SHALL control forwarding.
- Defined: fwdN_hit = w_enable && (w_addr == rsN) && (rsN != 0); fwdN_data = w_data when fwdN_hit, else 0.
- Undefined: fwd1_hit, fwd2_hit, fwd1_data and fwd2_data are tied to 0 and no compare logic is built.
- Ports exist in both builds.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then alu_valid=1, rd=5, data=32'hDEADBEEF -> alu_ready=1 same cycle; next cycle w_enable=1, w_addr=5, w_data=32'hDEADBEEF.
- All three valid and held for 3 cycles after reset (rd=1/2/3) -> grants alu, fpu, mem in that order; w_addr sequence 1,2,3; conflict_cnt=2 after the third cycle (only two of the three cycles are contended).
- mem_valid=1, rd=0, data=32'h1234 -> mem_ready=1; next cycle w_enable=0; w_addr/w_data unchanged.
- With WB_FORWARD_EN, w_enable=1, w_addr=7, w_data=32'hCAFE, rs1=7, rs2=0 -> fwd1_hit=1, fwd1_data=32'hCAFE, fwd2_hit=0; without the macro -> all forwarding outputs 0.
- rst=1 in the same cycle as fpu_valid=1 -> fpu_ready=0; next cycle w_enable=0; fpu is granted after rst falls.
- Hold alu_valid and fpu_valid high for 70000 cycles -> conflict_cnt stops at 16'hFFFF.
